// File: rtl/thermometer_sweep.sv
// thermometer_sweep
//   Sequential thermometer decoder. A target level (0..BITS) is accepted over a
//   valid/ready handshake; LED then ramps one step every STEP_CYCLES clocks toward
//   the target, and DONE pulses for one cycle when LED reaches it.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   LEVEL_VALID  LEVEL is valid this cycle
//   LEVEL_READY  block can accept a new LEVEL (high in IDLE)
//   LEVEL        requested target level; values above BITS are clamped to BITS
//   LED          registered thermometer code, LED[i] = (i < current level)
//   BUSY         ramp in progress
//   DONE         one-cycle pulse when LED reaches the target
module thermometer_sweep #(
    parameter int unsigned BITS        = 16,
    parameter int unsigned STEP_CYCLES = 4,
    localparam int unsigned LW         = $clog2(BITS) + 1,
    localparam int unsigned CW         = $clog2(STEP_CYCLES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LEVEL_VALID,
    output logic          LEVEL_READY,
    input  logic [LW-1:0] LEVEL,
    output logic [BITS-1:0] LED,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [LW-1:0] MaxLevel = LW'(BITS);
    localparam logic [CW-1:0] CntLast  = CW'(STEP_CYCLES - 1);

    typedef enum logic {StIdle, StRamp} state_e;

    state_e          r_state, w_state_nxt;
    logic [LW-1:0]   r_cur, w_cur_nxt;
    logic [LW-1:0]   r_target, w_target_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_up, w_up_nxt;
    logic            r_done, w_done_nxt;
    logic [BITS-1:0] r_led, w_led_nxt;
    logic [LW-1:0]   w_clamped;

    assign w_clamped = (LEVEL > MaxLevel) ? MaxLevel : LEVEL;

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_up_nxt     = r_up;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (LEVEL_VALID) begin
                    w_target_nxt = w_clamped;
                    if (w_clamped == r_cur) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = StRamp;
                        w_cnt_nxt   = '0;
                        // Direction is latched here and held for the whole ramp.
                        w_up_nxt    = (w_clamped > r_cur);
                    end
                end
            end
            StRamp: begin
                if (r_cnt == CntLast) begin
                    w_cnt_nxt = '0;
                    w_cur_nxt = r_up ? (r_cur + 1'b1) : (r_cur - 1'b1);
                    if (w_cur_nxt == r_target) begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // LED is registered from the next level so it changes on the same edge as r_cur.
    always_comb begin
        w_led_nxt = '0;
        for (int i = 0; i < BITS; i++) begin
            w_led_nxt[i] = (LW'(i) < w_cur_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cur    <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_up     <= 1'b0;
            r_done   <= 1'b0;
            r_led    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_up     <= w_up_nxt;
            r_done   <= w_done_nxt;
            r_led    <= w_led_nxt;
        end
    end

    assign LEVEL_READY = (r_state == StIdle);
    assign BUSY        = (r_state == StRamp);
    assign LED         = r_led;
    assign DONE        = r_done;

endmodule

// File: tb/tb_thermometer_sweep.sv
// tb_thermometer_sweep
//   Directed bench for thermometer_sweep. Two instances: STEP_CYCLES=4 (main
//   tests) and STEP_CYCLES=1 (fast-ramp build). Both share clk and rst_n.
module tb_thermometer_sweep;

    localparam int BITS = 16;
    localparam int LW   = $clog2(BITS) + 1;

    logic            clk;
    logic            rst_n;
    logic            valid4, valid1;
    logic [LW-1:0]   level4, level1;
    logic            ready4, ready1;
    logic [BITS-1:0] led4, led1;
    logic            busy4, busy1;
    logic            done4, done1;

    int n_total = 0;
    int n_bad   = 0;

    thermometer_sweep #(
        .BITS        (BITS),
        .STEP_CYCLES (4)
    ) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .LEVEL_VALID (valid4),
        .LEVEL_READY (ready4),
        .LEVEL       (level4),
        .LED         (led4),
        .BUSY        (busy4),
        .DONE        (done4)
    );

    thermometer_sweep #(
        .BITS        (BITS),
        .STEP_CYCLES (1)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .LEVEL_VALID (valid1),
        .LEVEL_READY (ready1),
        .LEVEL       (level1),
        .LED         (led1),
        .BUSY        (busy1),
        .DONE        (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BITS-1:0] thermo(input int n);
        logic [31:0] v;
        v = (32'h1 << n) - 32'h1;
        return v[BITS-1:0];
    endfunction

    // Leading-ones encoder: counts set bits from LED[0] upward.
    function automatic int encode(input logic [BITS-1:0] v);
        int n;
        n = 0;
        while (n < BITS && v[n]) n++;
        return n;
    endfunction

    function automatic logic [BITS-1:0] led_of(input bit sel);
        return sel ? led1 : led4;
    endfunction

    // Called at #1 after an edge; performs a one-cycle handshake.
    task automatic accept(input bit sel, input int lvl);
        check("ready_before_accept", sel ? ready1 : ready4, 1);
        if (sel) begin
            level1 = LW'(lvl);
            valid1 = 1'b1;
        end else begin
            level4 = LW'(lvl);
            valid4 = 1'b1;
        end
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        valid4 = 1'b0;
    endtask

    // Follows a ramp just after acceptance. inject>0 pulses LEVEL=9 into the
    // busy block before edge number 'inject'.
    task automatic ramp(input bit sel, input int from, input int to, input int s,
                        input int inject);
        int d, dir, last, exp_lvl;
        d    = (to > from) ? (to - from) : (from - to);
        dir  = (to > from) ? 1 : -1;
        last = d * s;
        check("busy_after_accept", sel ? busy1 : busy4, 1);
        check("ready_after_accept", sel ? ready1 : ready4, 0);
        check("led_after_accept", led_of(sel), thermo(from));
        for (int t = 1; t <= last; t++) begin
            if (t == inject) begin
                level4 = LW'(9);
                valid4 = 1'b1;
            end
            @(posedge clk);
            #1;
            valid4 = 1'b0;
            exp_lvl = from + dir * (t / s);
            check("ramp_led", led_of(sel), thermo(exp_lvl));
            check("ramp_done", sel ? done1 : done4, (t == last) ? 1 : 0);
            check("ramp_busy", sel ? busy1 : busy4, (t == last) ? 0 : 1);
        end
        check("ready_at_done", sel ? ready1 : ready4, 1);
        check("encoder_level", encode(led_of(sel)), to);
        @(posedge clk);
        #1;
        check("done_single_cycle", sel ? done1 : done4, 0);
        check("idle_after_done", sel ? busy1 : busy4, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        valid4 = 1'b0;
        valid1 = 1'b0;
        level4 = '0;
        level1 = '0;
        #2;
        check("rst_led", led4, 0);
        check("rst_ready", ready4, 1);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_led", led4, 0);
        check("post_rst_ready", ready4, 1);

        // Ramp up 0 -> 5: 20 cycles
        accept(0, 5);
        ramp(0, 0, 5, 4, 0);

        // Ramp down 5 -> 2: 12 cycles
        accept(0, 2);
        ramp(0, 5, 2, 4, 0);

        // Equal level: DONE right after the accepting edge, LED unchanged
        accept(0, 2);
        check("eq_done", done4, 1);
        check("eq_led", led4, thermo(2));
        check("eq_busy", busy4, 0);
        check("eq_ready", ready4, 1);
        @(posedge clk);
        #1;
        check("eq_done_clear", done4, 0);
        check("eq_led_hold", led4, 16'h0003);

        // Clamp 20 -> 16 (56 cycles), with an ignored LEVEL=9 pulse mid-ramp
        accept(0, 20);
        ramp(0, 2, 16, 4, 10);
        check("clamp_led_full", led4, 16'hFFFF);

        // Back down to 0, then reset during a 0 -> 16 ramp
        accept(0, 0);
        ramp(0, 16, 0, 4, 0);
        accept(0, 16);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
        end
        check("midramp_led", led4, thermo(2));
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_led", led4, 0);
        check("async_rst_busy", busy4, 0);
        check("async_rst_done", done4, 0);
        check("async_rst_ready", ready4, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst_led", led4, 0);
        check("after_rst_done", done4, 0);
        check("after_rst_busy", busy4, 0);
        accept(0, 3);
        ramp(0, 0, 3, 4, 0);

        // STEP_CYCLES=1 instance: 0 -> 16 in exactly 16 cycles
        accept(1, 16);
        ramp(1, 0, 16, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
